// File: rtl/mem_ctrl.sv
// Byte-wide single-port RAM arbiter between instruction fetch and the MEM stage.
// MEM accesses are serialised byte by byte and take priority; IF is stalled and replays.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_request,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [1:0]        mem_request,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    output logic [7:0]        mem_ctrl_data,
    output logic [1:0]        if_or_mem_o,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_stall_req,
    output logic [1:0]        dbg_state
);

    // Handshake: MEM holds mem_request (01 load, 10 store) until it sees the one-cycle
    // mem_done pulse; the request is ignored in DONE so it cannot start a second access.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_IF   = 2'b01;
    localparam logic [1:0] TAG_MEM  = 2'b10;

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [1:0]        tag_q, tag_d;
    logic [31:0]       rdata_q;
    logic [2:0]        len_eff;
    logic [2:0]        last_k;
    logic [ADDR_W-1:0] byte_addr;
    logic [31:0]       wshift;
    logic [ADDR_W-1:0] a_c;
    logic [7:0]        dout_c;
    logic              wr_c, done_c, stall_c;

    assign len_eff   = (mem_len == 3'd1 || mem_len == 3'd2) ? mem_len : 3'd4;
    assign last_k    = len_eff - 3'd1;
    assign byte_addr = mem_addr + {{(ADDR_W-3){1'b0}}, k_q};
    assign wshift    = mem_wdata >> {k_q[1:0], 3'b000};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tag_d   = TAG_NONE;
        a_c     = if_addr;
        dout_c  = 8'h00;
        wr_c    = 1'b0;
        done_c  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_request == 2'b01) begin
                    state_d = LOAD;
                    k_d     = 3'd0;
                    stall_c = 1'b1;
                    a_c     = mem_addr;
                end else if (mem_request == 2'b10) begin
                    state_d = STORE;
                    k_d     = 3'd0;
                    stall_c = 1'b1;
                    a_c     = mem_addr;
                end else begin
                    tag_d = if_request ? TAG_IF : TAG_NONE;
                end
            end
            LOAD: begin
                stall_c = 1'b1;
                a_c     = byte_addr;
                // Cycle k == len issues no useful read; it only collects the last byte.
                if (k_q == len_eff) begin
                    state_d = DONE;
                end else begin
                    k_d   = k_q + 3'd1;
                    tag_d = TAG_MEM;
                end
            end
            STORE: begin
                stall_c = 1'b1;
                a_c     = byte_addr;
                wr_c    = 1'b1;
                dout_c  = wshift[7:0];
                tag_d   = TAG_MEM;
                if (k_q == last_k) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
                tag_d   = if_request ? TAG_IF : TAG_NONE;
            end
            default: state_d = IDLE;
        endcase
        if (!rdy) begin
            state_d = state_q;
            k_d     = k_q;
            tag_d   = tag_q;
            wr_c    = 1'b0;
            done_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            tag_q   <= TAG_NONE;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tag_q   <= tag_d;
        end
    end

    // Byte k-1 arrives on mem_din during LOAD cycle k; clearing on entry zero-extends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'h0;
        end else if (rdy) begin
            if (state_q == IDLE && mem_request == 2'b01) begin
                rdata_q <= 32'h0;
            end else if (state_q == LOAD) begin
                case (k_q)
                    3'd1:    rdata_q[7:0]   <= mem_din;
                    3'd2:    rdata_q[15:8]  <= mem_din;
                    3'd3:    rdata_q[23:16] <= mem_din;
                    3'd4:    rdata_q[31:24] <= mem_din;
                    default: rdata_q        <= rdata_q;
                endcase
            end
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign mem_a         = rst ? a_c : {ADDR_W{1'b0}};
    assign mem_dout      = rst ? dout_c : 8'h00;
    assign mem_wr        = rst & wr_c;
    assign mem_done      = rst & done_c;
    assign mem_stall_req = rst & stall_c;
    assign mem_ctrl_data = rst ? mem_din : 8'h00;
    assign if_or_mem_o   = tag_q;
    assign mem_rdata     = rdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model, a vector table for IF streaming and a
// colliding word load, plus hand sequences for stores, rdy stalls, wrap-around and reset.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_request;
  logic [31:0] if_addr;
  logic [1:0]  mem_request;
  logic [31:0] mem_addr;
  logic [2:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_ctrl_data;
  logic [1:0]  if_or_mem_o;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall_req;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  logic [7:0] ram [1024];
  logic [31:0] exp_q[$];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_request(if_request), .if_addr(if_addr),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_din(mem_din), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_ctrl_data(mem_ctrl_data), .if_or_mem_o(if_or_mem_o),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall_req(mem_stall_req),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
    $fatal(1, "watchdog");
  end

  // RAM model: synchronous write, read data one cycle after the address; image reloads in reset
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h000] <= 8'h13; ram[10'h001] <= 8'h05;
      ram[10'h008] <= 8'h5A; ram[10'h009] <= 8'hC3;
      ram[10'h021] <= 8'h77;
      ram[10'h100] <= 8'h78; ram[10'h101] <= 8'h56;
      ram[10'h102] <= 8'h34; ram[10'h103] <= 8'h12;
      ram[10'h3FF] <= 8'hAB;
      mem_din <= 8'h00;
    end else begin
      if (mem_wr) begin
        ram[mem_a[9:0]] <= mem_dout;
        wr_count <= wr_count + 1;
      end
      mem_din <= ram[mem_a[9:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every mem_done pulse must present the next expected mem_rdata
  always @(negedge clk) begin
    if (rst && mem_done) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 32'h1, 32'h0);
      end else begin
        check("sb_rdata", mem_rdata, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ifa, input logic [1:0] mreq,
                       input logic [31:0] maddr, input logic [2:0] mlen, input logic [31:0] wd);
    if_request  = ifr;
    if_addr     = ifa;
    mem_request = mreq;
    mem_addr    = maddr;
    mem_len     = mlen;
    mem_wdata   = wd;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_done) seen = 1'b1;
      else next_cycle();
    end
    if (!seen) check(name, 32'h0, 32'h1);
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  mreq;
    logic [31:0] maddr;
    logic [2:0]  mlen;
    logic [31:0] exp_a;
    logic        exp_stall;
    logic        exp_done;
    logic [1:0]  exp_tag;
    logic        chk_data;
    logic [7:0]  exp_data;
  } vec_t;

  function automatic vec_t row(input logic ifr, input logic [31:0] ifa, input logic [1:0] mreq,
                               input logic [31:0] maddr, input logic [31:0] ea, input logic es,
                               input logic ed, input logic [1:0] et, input logic cd,
                               input logic [7:0] edata);
    vec_t v;
    v.if_req = ifr; v.if_addr = ifa; v.mreq = mreq; v.maddr = maddr; v.mlen = 3'd4;
    v.exp_a = ea; v.exp_stall = es; v.exp_done = ed; v.exp_tag = et;
    v.chk_data = cd; v.exp_data = edata;
    return v;
  endfunction

  vec_t vecs[14];
  int   base;

  initial begin
    // IF stream 0..3, then a word load colliding with IF, then IF resumes
    vecs[0]  = row(1, 32'h0, 2'b00, 32'h0,   32'h0,   0, 0, 2'b00, 0, 8'h00);
    vecs[1]  = row(1, 32'h1, 2'b00, 32'h0,   32'h1,   0, 0, 2'b01, 1, 8'h13);
    vecs[2]  = row(1, 32'h2, 2'b00, 32'h0,   32'h2,   0, 0, 2'b01, 1, 8'h05);
    vecs[3]  = row(1, 32'h3, 2'b00, 32'h0,   32'h3,   0, 0, 2'b01, 1, 8'h00);
    vecs[4]  = row(0, 32'h4, 2'b00, 32'h0,   32'h4,   0, 0, 2'b01, 1, 8'h00);
    vecs[5]  = row(1, 32'h8, 2'b01, 32'h100, 32'h100, 1, 0, 2'b00, 0, 8'h00);
    vecs[6]  = row(1, 32'h8, 2'b01, 32'h100, 32'h100, 1, 0, 2'b00, 0, 8'h00);
    vecs[7]  = row(1, 32'h8, 2'b01, 32'h100, 32'h101, 1, 0, 2'b10, 0, 8'h00);
    vecs[8]  = row(1, 32'h8, 2'b01, 32'h100, 32'h102, 1, 0, 2'b10, 0, 8'h00);
    vecs[9]  = row(1, 32'h8, 2'b01, 32'h100, 32'h103, 1, 0, 2'b10, 0, 8'h00);
    vecs[10] = row(1, 32'h8, 2'b01, 32'h100, 32'h104, 1, 0, 2'b10, 0, 8'h00);
    vecs[11] = row(1, 32'h8, 2'b01, 32'h100, 32'h8,   0, 1, 2'b00, 0, 8'h00);
    vecs[12] = row(1, 32'h9, 2'b00, 32'h0,   32'h9,   0, 0, 2'b01, 1, 8'h5A);
    vecs[13] = row(0, 32'h9, 2'b00, 32'h0,   32'h9,   0, 0, 2'b01, 1, 8'hC3);

    rst = 1'b0;
    rdy = 1'b1;
    drive(1, 32'h1234, 2'b01, 32'h100, 3'd4, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_wr", {31'h0, mem_wr}, 32'h0);
    check("rst_stall", {31'h0, mem_stall_req}, 32'h0);
    check("rst_tag", {30'h0, if_or_mem_o}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    next_cycle();
    rst = 1'b1;

    exp_q.push_back(32'h12345678);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].mreq, vecs[i].maddr, vecs[i].mlen, 32'h0);
      @(negedge clk);
      check($sformatf("v%0d_mem_a", i), mem_a, vecs[i].exp_a);
      check($sformatf("v%0d_stall", i), {31'h0, mem_stall_req}, {31'h0, vecs[i].exp_stall});
      check($sformatf("v%0d_done", i), {31'h0, mem_done}, {31'h0, vecs[i].exp_done});
      check($sformatf("v%0d_tag", i), {30'h0, if_or_mem_o}, {30'h0, vecs[i].exp_tag});
      check($sformatf("v%0d_wr", i), {31'h0, mem_wr}, 32'h0);
      if (vecs[i].chk_data)
        check($sformatf("v%0d_data", i), {24'h0, mem_ctrl_data}, {24'h0, vecs[i].exp_data});
      next_cycle();
    end
    check("word_rdata", mem_rdata, 32'h12345678);

    // byte store: one write of the low byte, neighbour untouched
    exp_q.push_back(32'h12345678);
    drive(0, 32'h0, 2'b10, 32'h20, 3'd1, 32'hAABBCCDD);
    @(negedge clk);
    check("bs_accept_stall", {31'h0, mem_stall_req}, 32'h1);
    check("bs_accept_wr", {31'h0, mem_wr}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("bs_wr", {31'h0, mem_wr}, 32'h1);
    check("bs_a", mem_a, 32'h20);
    check("bs_dout", {24'h0, mem_dout}, 32'hDD);
    next_cycle();
    @(negedge clk);
    check("bs_done", {31'h0, mem_done}, 32'h1);
    check("bs_done_wr", {31'h0, mem_wr}, 32'h0);
    check("bs_done_stall", {31'h0, mem_stall_req}, 32'h0);
    next_cycle();
    drive(1, 32'h30, 2'b11, 32'h20, 3'd1, 32'h0);
    @(negedge clk);
    check("bs_ram20", {24'h0, ram[10'h020]}, 32'hDD);
    check("bs_ram21", {24'h0, ram[10'h021]}, 32'h77);
    check("req11_stall", {31'h0, mem_stall_req}, 32'h0);
    check("req11_mem_a", mem_a, 32'h30);
    next_cycle();
    @(negedge clk);
    check("req11_tag", {30'h0, if_or_mem_o}, 32'h1);

    // word store with rdy low for three cycles in the middle
    next_cycle();
    exp_q.push_back(32'h12345678);
    base = wr_count;
    drive(0, 32'h0, 2'b10, 32'h40, 3'd4, 32'h11223344);
    next_cycle();
    next_cycle();
    next_cycle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rdy_low%0d_wr", i), {31'h0, mem_wr}, 32'h0);
      check($sformatf("rdy_low%0d_state", i), {30'h0, dbg_state}, 32'h2);
      next_cycle();
    end
    rdy = 1'b1;
    wait_done("ws_done_timeout");
    next_cycle();
    drive(0, 32'h0, 2'b00, 32'h0, 3'd4, 32'h0);
    @(negedge clk);
    check("ws_writes", wr_count - base, 32'd4);
    check("ws_ram", {ram[10'h043], ram[10'h042], ram[10'h041], ram[10'h040]}, 32'h11223344);

    // halfword load wrapping from 0xFFFFFFFF to 0x0, upper bytes zero
    next_cycle();
    exp_q.push_back(32'h000013AB);
    drive(0, 32'h0, 2'b01, 32'hFFFFFFFF, 3'd2, 32'h0);
    next_cycle();
    @(negedge clk);
    check("wrap_a0", mem_a, 32'hFFFFFFFF);
    next_cycle();
    @(negedge clk);
    check("wrap_a1", mem_a, 32'h0);
    next_cycle();
    wait_done("hw_done_timeout");
    next_cycle();
    drive(0, 32'h0, 2'b00, 32'h0, 3'd4, 32'h0);
    @(negedge clk);
    check("hw_rdata", mem_rdata, 32'h000013AB);

    // asynchronous reset in the middle of a load
    next_cycle();
    drive(1, 32'h55, 2'b01, 32'h100, 3'd4, 32'h0);
    next_cycle();
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    check("ar_mem_a", mem_a, 32'h0);
    check("ar_stall", {31'h0, mem_stall_req}, 32'h0);
    check("ar_rdata", mem_rdata, 32'h0);
    check("ar_state", {30'h0, dbg_state}, 32'h0);
    check("ar_tag", {30'h0, if_or_mem_o}, 32'h0);
    drive(0, 32'h0, 2'b00, 32'h0, 3'd4, 32'h0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("ar_release_state", {30'h0, dbg_state}, 32'h0);
    check("ar_release_stall", {31'h0, mem_stall_req}, 32'h0);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
